loop_table: RTL and testbench

LOOP_TABLE -- requirements
Module: loop_table

---
 rtl/loop_table_pkg.sv | 20 ++
 rtl/loop_table_if.sv | 39 +++
 rtl/loop_entry_mux.sv | 22 ++
 rtl/loop_table.sv | 107 ++++++++++
 tb/tb_loop_table.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/loop_table_pkg.sv
// Shared types and defaults for the loop table: entry width, decoded
// instruction layout and output-stage state encoding.
package loop_table_pkg;

    localparam int LOOP_ENTRY_W = 24;
    localparam int LOOP_DEPTH   = 8;
    localparam int LOOP_CNT_W   = 16;

    typedef struct packed {
        logic                    new_loop;
        logic [LOOP_ENTRY_W-1:0] entry;
        logic                    independent;
    } decoded_loop_instruction;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/loop_table_if.sv
// Bundles the loop table write port, lookup request and response handshakes.
// slave = the table itself, master = whoever drives writes and lookups.
interface loop_table_if #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 24,
    parameter int CNT_W   = 16
) ();
    localparam int AW = $clog2(DEPTH);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic [CNT_W-1:0]   wr_trip;

    logic               req_valid;
    logic               req_ready;
    logic [AW-1:0]      req_addr;
    logic               req_new_loop;
    logic               req_independent;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [ENTRY_W+1:0] loop_instr;
    logic               rsp_last;

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_trip,
        input  req_valid, req_addr, req_new_loop, req_independent,
        input  rsp_ready,
        output req_ready, rsp_valid, loop_instr, rsp_last
    );

    modport master (
        output wr_en, wr_addr, wr_data, wr_trip,
        output req_valid, req_addr, req_new_loop, req_independent,
        output rsp_ready,
        input  req_ready, rsp_valid, loop_instr, rsp_last
    );
endinterface

// File: rtl/loop_entry_mux.sv
// Purpose: DEPTH-way selection of one table word by index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state.
module loop_entry_mux #(
    parameter int DEPTH = 8,
    parameter int W     = 24
) (
    input  logic [W-1:0]             data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] sel,
    output logic [W-1:0]             dout
);
    localparam int AW = $clog2(DEPTH);

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == AW'(i)) begin
                dout = data[i];
            end
        end
    end
endmodule

// File: rtl/loop_table.sv
// Purpose: loop entry table with per-entry trip/remaining counters and a lookup port.
// Latency: one cycle from request accept to registered response.
// Backpressure: single output register; req_ready = !rsp_valid || rsp_ready, writes never stall.
module loop_table
    import loop_table_pkg::*;
#(
    parameter int DEPTH   = LOOP_DEPTH,
    parameter int ENTRY_W = LOOP_ENTRY_W,
    parameter int CNT_W   = LOOP_CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    loop_table_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] entry_q [DEPTH];
    logic [CNT_W-1:0]   trip_q  [DEPTH];
    logic [CNT_W-1:0]   rem_q   [DEPTH];

    logic [ENTRY_W-1:0] entry_sel;
    logic [CNT_W-1:0]   trip_sel;
    logic [CNT_W-1:0]   rem_sel;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   rem_next;

    rsp_state_e         state_q;
    rsp_state_e         state_d;
    logic               accept;
    logic               take;
    logic [ENTRY_W+1:0] instr_q;
    logic               last_q;

    loop_entry_mux #(.DEPTH(DEPTH), .W(ENTRY_W)) u_entry_mux (
        .data (entry_q),
        .sel  (bus.req_addr),
        .dout (entry_sel)
    );

    loop_entry_mux #(.DEPTH(DEPTH), .W(CNT_W)) u_trip_mux (
        .data (trip_q),
        .sel  (bus.req_addr),
        .dout (trip_sel)
    );

    loop_entry_mux #(.DEPTH(DEPTH), .W(CNT_W)) u_rem_mux (
        .data (rem_q),
        .sel  (bus.req_addr),
        .dout (rem_sel)
    );

    assign bus.req_ready  = (state_q == ST_IDLE) || bus.rsp_ready;
    assign bus.rsp_valid  = (state_q == ST_FULL);
    assign bus.loop_instr = instr_q;
    assign bus.rsp_last   = last_q;

    assign accept = bus.req_valid && bus.req_ready;
    assign take   = (state_q == ST_FULL) && bus.rsp_ready;

    // A new loop restarts from the programmed trip count; otherwise continue and floor at zero.
    assign count    = bus.req_new_loop ? trip_sel : rem_sel;
    assign rem_next = (count == '0) ? '0 : count - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)          state_d = ST_FULL;
            ST_FULL: if (take && !accept) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= {bus.req_new_loop, entry_sel, bus.req_independent};
                last_q  <= (count <= CNT_W'(1));
            end
        end
    end

    // A same-address write overrides the counter update of a concurrent lookup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
                trip_q[i]  <= '0;
                rem_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
                    entry_q[i] <= bus.wr_data;
                    trip_q[i]  <= bus.wr_trip;
                    rem_q[i]   <= bus.wr_trip;
                end else if (accept && (bus.req_addr == AW'(i))) begin
                    rem_q[i] <= rem_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_loop_table.sv
// Self-checking bench for loop_table: directed vector table, handshake corner
// sequences and randomized traffic against a transaction-level model.
module tb_loop_table;
    import loop_table_pkg::*;

    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 24;
    localparam int CNT_W   = 16;
    localparam int AW      = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    loop_table_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .CNT_W(CNT_W)) bus ();

    loop_table #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: table contents plus the response waiting to be taken.
    typedef struct {
        logic [ENTRY_W+1:0] instr;
        logic               last;
    } rsp_t;

    logic [ENTRY_W-1:0] m_entry [DEPTH];
    int                 m_trip  [DEPTH];
    int                 m_rem   [DEPTH];
    rsp_t               m_q [$];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_entry[i] = '0;
            m_trip[i]  = 0;
            m_rem[i]   = 0;
        end
        m_q.delete();
    endtask

    // Called at posedge+1: drive inputs, check outputs mid-cycle, update model, advance one edge.
    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [ENTRY_W-1:0] wd,
                         input logic [CNT_W-1:0] wt, input logic rv, input logic [AW-1:0] ra,
                         input logic nl, input logic ind, input logic rr);
        logic exp_ready;
        int   cnt;
        rsp_t r;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_trip = wt;
        bus.req_valid = rv; bus.req_addr = ra; bus.req_new_loop = nl; bus.req_independent = ind;
        bus.rsp_ready = rr;
        #3;
        exp_ready = (m_q.size() == 0) || rr;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("loop_instr", 32'(bus.loop_instr), 32'(m_q[0].instr));
            check("rsp_last", 32'(bus.rsp_last), 32'(m_q[0].last));
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (m_q.size() != 0 && rr) void'(m_q.pop_front());
        if (rv && exp_ready) begin
            cnt = nl ? m_trip[ra] : m_rem[ra];
            r.instr = decoded_loop_instruction'{nl, m_entry[ra], ind};
            r.last  = (cnt <= 1);
            m_q.push_back(r);
            m_rem[ra] = (cnt > 0) ? cnt - 1 : 0;
        end
        if (we) begin
            m_entry[wa] = wd;
            m_trip[wa]  = int'(wt);
            m_rem[wa]   = int'(wt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic               we;
        logic [AW-1:0]      wa;
        logic [ENTRY_W-1:0] wd;
        logic [CNT_W-1:0]   wt;
        logic               rv;
        logic [AW-1:0]      ra;
        logic               nl;
        logic               ind;
        logic               rr;
        logic               exp_vld;
        logic [ENTRY_W+1:0] exp_instr;
        logic               exp_last;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_trip = '0;
        bus.req_valid = 0; bus.req_addr = '0; bus.req_new_loop = 0; bus.req_independent = 0;
        bus.rsp_ready = 1;
        model_reset();

        #12;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_last", 32'(bus.rsp_last), 32'd0);
        check("reset_loop_instr", 32'(bus.loop_instr), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        tbl[0]  = '{1'b1, 3'd3, 24'hABCDEF, 16'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 24'h0, 16'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, {1'b1, 24'hABCDEF, 1'b0}, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 24'h0, 16'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, {1'b0, 24'hABCDEF, 1'b1}, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 24'h0, 16'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 24'hABCDEF, 1'b0}, 1'b1};
        tbl[4]  = '{1'b0, 3'd0, 24'h0, 16'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, {1'b0, 24'hABCDEF, 1'b1}, 1'b1};
        tbl[5]  = '{1'b0, 3'd0, 24'h0, 16'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 24'hABCDEF, 1'b0}, 1'b1};
        tbl[6]  = '{1'b1, 3'd1, 24'h222222, 16'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b0};
        tbl[7]  = '{1'b1, 3'd1, 24'h111111, 16'd1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 24'h222222, 1'b0}, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 24'h0, 16'd0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, {1'b0, 24'h111111, 1'b1}, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 24'h0, 16'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, {1'b1, 24'hABCDEF, 1'b0}, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 24'h0, 16'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wt, tbl[i].rv, tbl[i].ra,
                  tbl[i].nl, tbl[i].ind, tbl[i].rr);
            check($sformatf("tbl%0d_vld", i), 32'(bus.rsp_valid), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) begin
                check($sformatf("tbl%0d_instr", i), 32'(bus.loop_instr), 32'(tbl[i].exp_instr));
                check($sformatf("tbl%0d_last", i), 32'(bus.rsp_last), 32'(tbl[i].exp_last));
            end
        end

        // Stall: response held four cycles, then released together with a new accept.
        cycle(1'b0, '0, '0, '0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, '0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
            check($sformatf("stall%0d_instr", i), 32'(bus.loop_instr), 32'({1'b1, 24'hABCDEF, 1'b0}));
        end
        cycle(1'b0, '0, '0, '0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
        check("stall_release_vld", 32'(bus.rsp_valid), 32'd1);
        check("stall_release_instr", 32'(bus.loop_instr), 32'({1'b0, 24'h0, 1'b1}));
        idle_cycle();

        // Reset while a response is pending.
        cycle(1'b0, '0, '0, '0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_vld", 32'(bus.rsp_valid), 32'd0);
        check("async_rst_last", 32'(bus.rsp_last), 32'd0);
        check("async_rst_instr", 32'(bus.loop_instr), 32'd0);
        model_reset();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b0, '0, '0, '0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
        check("post_rst_vld", 32'(bus.rsp_valid), 32'd1);
        check("post_rst_instr", 32'(bus.loop_instr), 32'd0);
        check("post_rst_last", 32'(bus.rsp_last), 32'd1);
        cycle(1'b0, '0, '0, '0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
        idle_cycle();

        // Back-to-back streaming across every address.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, AW'(i), ENTRY_W'($urandom), CNT_W'($urandom_range(0, 4)),
                  1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'($urandom), 1'($urandom), 1'b1);
        end
        idle_cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 3) == 0, AW'($urandom), ENTRY_W'($urandom),
                  (($urandom % 8) == 0) ? 16'hFFFF : CNT_W'($urandom_range(0, 3)),
                  ($urandom % 4) != 0, AW'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom % 4) != 0);
        end
        idle_cycle();
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
